// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   localparam int CLA_GRP_W = 4;

   function automatic int nGroups(input int width);
      return width / CLA_GRP_W;
   endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group; c3 (carry into the group MSB) feeds overflow.
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GRP_W-1:0] a,
   input  logic [CLA_GRP_W-1:0] b,
   input  logic                 cin,
   output logic [CLA_GRP_W-1:0] sum,
   output logic                 cout,
   output logic                 c3
);

   logic [CLA_GRP_W-1:0] p;
   logic [CLA_GRP_W-1:0] g;
   logic [CLA_GRP_W-1:0] c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c;
   assign c3  = c[3];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: LAT = WIDTH/4/GPS stages, GPS 4-bit groups per stage.
// Define CLA_OVF_EN to register signed overflow alongside the sum; otherwise out_ovf is 0.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GPS   = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NG  = nGroups(WIDTH);
   localparam int LAT = NG / GPS;
   localparam int SW  = GPS * CLA_GRP_W;

   logic en;

   // The whole pipe advances in lockstep; bubbles are not squeezed out.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   genvar gi, gj;
   generate
      for (gi = 0; gi < LAT; gi++) begin : stg
         localparam int LO = gi * SW;
         localparam int RW = WIDTH - LO;

         logic [RW-1:0]    a_cur;
         logic [RW-1:0]    b_cur;
         logic             c_cur;
         logic             v_cur;
         logic [GPS:0]     cc;
         logic [GPS-1:0]   c3_g;
         logic [SW-1:0]    gsum;
         logic [LO+SW-1:0] s_next;
         logic [LO+SW-1:0] s_reg;
         logic             c_reg;
         logic             v_reg;
         logic             c3_unused;

         if (gi == 0) begin : src
            assign a_cur  = in_a;
            assign b_cur  = in_b ^ {WIDTH{in_sub}};
            assign c_cur  = in_cin ^ in_sub;
            assign v_cur  = in_valid;
            assign s_next = gsum;
         end else begin : src
            // Only the not-yet-summed upper operand bits travel with the beat.
            assign a_cur  = stg[gi-1].fwd.a_reg;
            assign b_cur  = stg[gi-1].fwd.b_reg;
            assign c_cur  = stg[gi-1].c_reg;
            assign v_cur  = stg[gi-1].v_reg;
            assign s_next = {gsum, stg[gi-1].s_reg};
         end

         assign cc[0] = c_cur;

         for (gj = 0; gj < GPS; gj++) begin : grp
            cla_group4 u_grp (
               .a    (a_cur[gj*CLA_GRP_W +: CLA_GRP_W]),
               .b    (b_cur[gj*CLA_GRP_W +: CLA_GRP_W]),
               .cin  (cc[gj]),
               .sum  (gsum[gj*CLA_GRP_W +: CLA_GRP_W]),
               .cout (cc[gj+1]),
               .c3   (c3_g[gj])
            );
         end

         // Only the MSB group's c3 matters, and only for overflow.
         assign c3_unused = ^c3_g;

         if (gi < LAT-1) begin : fwd
            logic [RW-SW-1:0] a_reg;
            logic [RW-SW-1:0] b_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_reg <= '0;
                  b_reg <= '0;
               end else if (en) begin
                  a_reg <= a_cur[RW-1:SW];
                  b_reg <= b_cur[RW-1:SW];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_reg <= '0;
               c_reg <= 1'b0;
               v_reg <= 1'b0;
            end else if (en) begin
               s_reg <= s_next;
               c_reg <= cc[GPS];
               v_reg <= v_cur;
            end
         end
      end
   endgenerate

   assign out_valid = stg[LAT-1].v_reg;
   assign out_sum   = stg[LAT-1].s_reg;
   assign out_cout  = stg[LAT-1].c_reg;

`ifdef CLA_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (en) begin
         ovf_reg <= stg[LAT-1].c3_g[GPS-1] ^ stg[LAT-1].cc[GPS];
      end
   end

   assign out_ovf = ovf_reg;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: directed table, flow-control sequences, random traffic
// on the 16/1 build plus 16/4 and 32/2 instances checked against an arithmetic reference.
module tb_cla_pipe_addsub;

   localparam int LAT = 4;
`ifdef CLA_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct packed {
      logic        ovf;
      logic        cout;
      logic [31:0] sum;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a32;
   logic [31:0] b32;
   logic        cin;
   logic        sub;

   logic        in_ready, out_valid, out_cout, out_ovf;
   logic [15:0] out_sum;
   logic        rdy4, ov4, co4, of4;
   logic [15:0] sum4;
   logic        rdy32, ov32, co32, of32;
   logic [31:0] sum32;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int n_out_main = 0;
   res_t q_main[$];
   res_t q4[$];
   res_t q32[$];
   int   out_times[$];

   always #5 clk = ~clk;

   cla_pipe_addsub #(.WIDTH(16), .GPS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(a32[15:0]), .in_b(b32[15:0]), .in_cin(cin), .in_sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf)
   );

   cla_pipe_addsub #(.WIDTH(16), .GPS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
      .in_a(a32[15:0]), .in_b(b32[15:0]), .in_cin(cin), .in_sub(sub),
      .out_valid(ov4), .out_ready(1'b1), .out_sum(sum4),
      .out_cout(co4), .out_ovf(of4)
   );

   cla_pipe_addsub #(.WIDTH(32), .GPS(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .in_a(a32), .in_b(b32), .in_cin(cin), .in_sub(sub),
      .out_valid(ov32), .out_ready(1'b1), .out_sum(sum32),
      .out_cout(co32), .out_ovf(of32)
   );

   // Reference: plain (w+1)-bit arithmetic; overflow from operand/result signs.
   function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input logic sb, input int w);
      logic [63:0] mask, av, bv, full;
      res_t r;
      mask   = (64'd1 << w) - 64'd1;
      av     = {32'd0, a} & mask;
      bv     = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
      full   = av + bv + {63'd0, ci ^ sb};
      r.sum  = 32'(full & mask);
      r.cout = full[w];
      r.ovf  = OVF_ON && (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0000_7FFF;
         2:       return 32'h8000_8000;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic rnd_beat();
      a32 = rnd_op();
      b32 = rnd_op();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: handshakes sampled on the falling edge take effect on the next rising edge.
   initial forever begin
      res_t e;
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
         q_main.delete();
         q4.delete();
         q32.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q_main.size() == 0) begin
               check("main_unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
               e = q_main.pop_front();
               $display("[TB] w16g1 sum=%h cout=%b ovf=%b exp=%h/%b/%b", out_sum, out_cout, out_ovf,
                        e.sum[15:0], e.cout, e.ovf);
               check("main_sum", out_sum, e.sum[15:0]);
               check("main_cout", out_cout, e.cout);
               check("main_ovf", out_ovf, e.ovf);
               out_times.push_back(cycle);
               n_out_main++;
            end
         end
         if (ov4) begin
            if (q4.size() == 0) begin
               check("g4_unexpected_out", {63'd0, ov4}, 64'd0);
            end else begin
               e = q4.pop_front();
               $display("[TB] w16g4 sum=%h cout=%b ovf=%b", sum4, co4, of4);
               check("g4_result", {of4, co4, sum4}, {e.ovf, e.cout, e.sum[15:0]});
            end
         end
         if (ov32) begin
            if (q32.size() == 0) begin
               check("w32_unexpected_out", {63'd0, ov32}, 64'd0);
            end else begin
               e = q32.pop_front();
               $display("[TB] w32g2 sum=%h cout=%b ovf=%b", sum32, co32, of32);
               check("w32_result", {of32, co32, sum32}, {e.ovf, e.cout, e.sum});
            end
         end
         if (in_valid && in_ready) q_main.push_back(ref_add(a32, b32, cin, sub, 16));
         if (in_valid && rdy4)     q4.push_back(ref_add(a32, b32, cin, sub, 16));
         if (in_valid && rdy32)    q32.push_back(ref_add(a32, b32, cin, sub, 32));
      end
   end

   initial begin
      vec_t vecs[11];
      logic [15:0] held_sum;
      logic        held_cout;
      int          n_before;

      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[6]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_cout", out_cout, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      // Directed table: one isolated beat each, exact latency checked.
      foreach (vecs[i]) begin
         a32 = {16'd0, vecs[i].a}; b32 = {16'd0, vecs[i].b};
         cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
         for (int k = 1; k <= LAT; k++) begin
            tick();
            in_valid = 1'b0;
            if (k == LAT-1) check($sformatf("vec%0d_early_valid", i), out_valid, 0);
         end
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), out_cout, vecs[i].cout);
         check($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].ovf & OVF_ON);
         tick();
      end

      // Eight back-to-back random beats must emerge on eight consecutive cycles.
      n_before = n_out_main;
      for (int i = 0; i < 8; i++) begin
         rnd_beat(); in_valid = 1'b1; tick();
      end
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
      check("b2b_count", n_out_main - n_before, 8);
      if (out_times.size() >= 8)
         check("b2b_no_gaps", out_times[out_times.size()-1] - out_times[out_times.size()-8], 7);
      else
         check("b2b_out_times", out_times.size(), 8);

      // Stall with a full pipe: outputs frozen, input blocked, nothing lost or duplicated.
      for (int i = 0; i < LAT; i++) begin
         rnd_beat(); in_valid = 1'b1; tick();
      end
      rnd_beat();
      held_sum = out_sum; held_cout = out_cout;
      check("stall_pre_valid", out_valid, 1);
      out_ready = 1'b0;
      #1;
      check("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold_valid", out_valid, 1);
         check("stall_hold_sum", out_sum, held_sum);
         check("stall_hold_cout", out_cout, held_cout);
         check("stall_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (LAT + 2) tick();
      check("stall_drained", q_main.size(), 0);

      // Reset with three beats in flight: outputs clear at once and none emerge later.
      for (int i = 0; i < 3; i++) begin
         a32 = 32'h1111_1111 * (i + 3); b32 = 32'h0101_0101; cin = 1'b1; sub = 1'b0;
         in_valid = 1'b1; tick();
      end
      in_valid = 1'b0;
      n_before = n_out_main;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sum", out_sum, 0);
      check("midrst_in_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;
      repeat (LAT + 3) tick();
      check("midrst_none_emerged", n_out_main - n_before, 0);

      // Random traffic with bubbles and random backpressure on the 16/1 instance.
      for (int i = 0; i < 300; i++) begin
         rnd_beat();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (LAT + 4) tick();
      check("final_main_empty", q_main.size(), 0);
      check("final_g4_empty", q4.size(), 0);
      check("final_w32_empty", q32.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
